// File: rtl/lif_spike_unit.sv
// Registered leaky-integrate-and-fire spike stage: threshold compare, membrane
// reset, programmable refractory period and saturating spike counter.
module lif_spike_unit #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned REFRAC_W = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [WIDTH-1:0]    u_in,
    input  logic [WIDTH-1:0]    theta,
    input  logic [REFRAC_W-1:0] refrac_len,
    input  logic                reset_mode,
    input  logic                cnt_clr,
    output logic                spike,
    output logic [WIDTH-1:0]    u_out,
    output logic                refractory,
    output logic [CNT_W-1:0]    spike_count
);

    typedef enum logic {
        ACTIVE = 1'b0,
        REFRAC = 1'b1
    } state_t;

    state_t              state;
    logic [REFRAC_W-1:0] rcnt;
    logic [WIDTH:0]      diff;
    logic                fire;
    logic                fire_step;

    // Extra MSB acts as the borrow: clear means u_in >= theta.
    assign diff      = {1'b0, u_in} - {1'b0, theta};
    assign fire      = ~diff[WIDTH];
    assign fire_step = en && (state == ACTIVE) && fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ACTIVE;
            spike       <= 1'b0;
            u_out       <= '0;
            refractory  <= 1'b0;
            rcnt        <= '0;
            spike_count <= '0;
        end else begin
            spike <= 1'b0;
            if (en) begin
                case (state)
                    ACTIVE: begin
                        if (fire) begin
                            spike <= 1'b1;
                            u_out <= reset_mode ? diff[WIDTH-1:0] : '0;
                            if (refrac_len != '0) begin
                                state      <= REFRAC;
                                rcnt       <= refrac_len;
                                refractory <= 1'b1;
                            end
                        end else begin
                            u_out <= u_in;
                        end
                    end
                    REFRAC: begin
                        u_out <= '0;
                        rcnt  <= rcnt - REFRAC_W'(1);
                        if (rcnt == REFRAC_W'(1)) begin
                            state      <= ACTIVE;
                            refractory <= 1'b0;
                        end
                    end
                    default: state <= ACTIVE;
                endcase
            end

            if (cnt_clr)
                spike_count <= '0;
            else if (fire_step && (spike_count != '1))
                spike_count <= spike_count + CNT_W'(1);
        end
    end

endmodule
